// File: rtl/bus_slave_mtimer.sv
// Memory-mapped RISC-V machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp,
// level timer interrupt, single-cycle non-stalling bus responder.
module bus_slave_mtimer #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_en,
   input  logic        bus_we,
   input  logic [29:0] bus_addr,
   input  logic [31:0] bus_wdata,
   input  logic [3:0]  bus_mask,
   output logic [31:0] bus_rdata,
   output logic        bus_valid,
   output logic        bus_stall,
   output logic        bus_err,
   output logic        timer_irq
);

   typedef enum logic [2:0] {
      REG_MTIME_LO    = 3'd0,
      REG_MTIME_HI    = 3'd1,
      REG_MTIMECMP_LO = 3'd2,
      REG_MTIMECMP_HI = 3'd3,
      REG_CTRL        = 3'd4,
      REG_PRESCALE    = 3'd5,
      REG_RSVD0       = 3'd6,
      REG_RSVD1       = 3'd7
   } reg_idx_e;

   logic [63:0] mtime;
   logic [63:0] mtime_next;
   logic [63:0] mtimecmp;
   logic [31:0] hi_shadow;
   logic [31:0] rd_mux;
   logic [15:0] prescale;
   logic [15:0] pcnt;
   logic [15:0] pcnt_next;
   logic        en;
   reg_idx_e    idx;
   logic        hit;
   logic        rsvd;
   logic        wr_ok;
   logic        rd_ok;
   logic        pre_wr;
   logic        mtime_inc;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return merged;
   endfunction

   assign bus_stall = 1'b0;
   assign idx       = reg_idx_e'(bus_addr[2:0]);
   assign hit       = bus_en && (bus_addr[29:3] == BASE_ADDR[31:5]);
   assign rsvd      = (idx == REG_RSVD0) || (idx == REG_RSVD1);
   assign wr_ok     = hit && bus_we && !rsvd;
   assign rd_ok     = hit && !bus_we && !rsvd;
   assign pre_wr    = wr_ok && (idx == REG_PRESCALE) && (bus_mask != 4'b0000);
   assign mtime_inc = en && (pcnt == prescale);

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      rd_mux = 32'd0;
      case (idx)
         REG_MTIME_LO:    rd_mux = mtime[31:0];
         REG_MTIME_HI:    rd_mux = hi_shadow;
         REG_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
         REG_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
         REG_CTRL:        rd_mux = {30'd0, timer_irq, en};
         REG_PRESCALE:    rd_mux = {16'd0, prescale};
         default:         rd_mux = 32'd0;
      endcase
   end

   // A software write to either mtime half wins over the tick for the whole 64-bit value.
   always_comb begin
      mtime_next = mtime;
      if (wr_ok && (idx == REG_MTIME_LO)) begin
         mtime_next[31:0] = merge_bytes(mtime[31:0], bus_wdata, bus_mask);
      end else if (wr_ok && (idx == REG_MTIME_HI)) begin
         mtime_next[63:32] = merge_bytes(mtime[63:32], bus_wdata, bus_mask);
      end else if (mtime_inc) begin
         mtime_next = mtime + 64'd1;
      end
   end

   always_comb begin
      pcnt_next = pcnt + 16'd1;
      if (pre_wr || !en || (pcnt == prescale)) begin
         pcnt_next = 16'd0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_valid <= 1'b0;
         bus_err   <= 1'b0;
         bus_rdata <= 32'd0;
      end else begin
         bus_valid <= hit && !rsvd;
         bus_err   <= hit && rsvd;
         bus_rdata <= rd_ok ? rd_mux : 32'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime     <= 64'd0;
         mtimecmp  <= '1;
         hi_shadow <= 32'd0;
         en        <= 1'b0;
         prescale  <= 16'd0;
         pcnt      <= 16'd0;
         timer_irq <= 1'b0;
      end else begin
         mtime     <= mtime_next;
         pcnt      <= pcnt_next;
         timer_irq <= en && (mtime >= mtimecmp);
         if (rd_ok && (idx == REG_MTIME_LO)) begin
            hi_shadow <= mtime[63:32];
         end
         if (wr_ok && (idx == REG_MTIMECMP_LO)) begin
            mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], bus_wdata, bus_mask);
         end
         if (wr_ok && (idx == REG_MTIMECMP_HI)) begin
            mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus_wdata, bus_mask);
         end
         if (wr_ok && (idx == REG_CTRL) && bus_mask[0]) begin
            en <= bus_wdata[0];
         end
         if (wr_ok && (idx == REG_PRESCALE)) begin
            prescale <= {bus_mask[1] ? bus_wdata[15:8] : prescale[15:8],
                         bus_mask[0] ? bus_wdata[7:0]  : prescale[7:0]};
         end
      end
   end

endmodule

// File: tb/tb_bus_slave_mtimer.sv
// Scoreboard bench for bus_slave_mtimer: stimulus queues expected responses,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_bus_slave_mtimer;

   localparam logic [31:0] BASE = 32'h0200_0000;

   typedef enum {K_VALID, K_ERR, K_NONE} kind_e;
   typedef struct {
      kind_e       kind;
      logic        chk;
      logic [31:0] lo;
      logic [31:0] hi;
      int          due;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_en, bus_we;
   logic [29:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_mask;
   logic [31:0] bus_rdata;
   logic        bus_valid, bus_stall, bus_err, timer_irq;

   exp_t        sb[$];
   int          pos_cnt = 0;
   int          total = 0;
   int          bad = 0;
   int          e_edge;
   logic [29:0] base_word;

   bus_slave_mtimer #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_mask(bus_mask), .bus_rdata(bus_rdata),
      .bus_valid(bus_valid), .bus_stall(bus_stall), .bus_err(bus_err), .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) pos_cnt <= pos_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input logic [31:0] act,
                              input logic [31:0] lo, input logic [31:0] hi);
      total++;
      if ($isunknown(act) || act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h..%0h", name, act, lo, hi);
      end
   endtask

   task automatic access(input logic [29:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] mask, input kind_e k, input logic chk,
                         input logic [31:0] lo, input logic [31:0] hi, input string name);
      exp_t e;
      @(negedge clk);
      bus_en    = 1'b1;
      bus_we    = we;
      bus_addr  = addr;
      bus_wdata = wdata;
      bus_mask  = mask;
      e.kind = k; e.chk = chk; e.lo = lo; e.hi = hi; e.due = pos_cnt + 1; e.name = name;
      sb.push_back(e);
   endtask

   task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] m, input string name);
      access(base_word + 30'(idx), 1'b1, d, m, K_VALID, 1'b0, 32'd0, 32'd0, name);
   endtask

   task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string name);
      access(base_word + 30'(idx), 1'b0, 32'd0, 4'd0, K_VALID, 1'b1, exp, exp, name);
   endtask

   task automatic idle();
      @(negedge clk);
      bus_en = 1'b0;
      bus_we = 1'b0;
   endtask

   // Monitor: compare the response due this cycle, and flag any response nobody asked for.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() > 0 && sb[0].due == pos_cnt) begin
         e = sb.pop_front();
         case (e.kind)
            K_VALID: begin
               check({e.name, " valid"}, 64'(bus_valid), 64'd1);
               check({e.name, " err"}, 64'(bus_err), 64'd0);
               if (e.chk) check_range({e.name, " rdata"}, bus_rdata, e.lo, e.hi);
            end
            K_ERR: begin
               check({e.name, " err"}, 64'(bus_err), 64'd1);
               check({e.name, " valid"}, 64'(bus_valid), 64'd0);
               check({e.name, " rdata"}, 64'(bus_rdata), 64'd0);
            end
            default: begin
               check({e.name, " valid/err"}, {62'd0, bus_valid, bus_err}, 64'd0);
            end
         endcase
      end else if (bus_valid || bus_err) begin
         check("unexpected response", {62'd0, bus_valid, bus_err}, 64'd0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      base_word = BASE[31:2];
      bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; bus_mask = '0;
      repeat (3) @(negedge clk);
      check("reset bus_valid", 64'(bus_valid), 64'd0);
      check("reset bus_err", 64'(bus_err), 64'd0);
      check("reset bus_rdata", 64'(bus_rdata), 64'd0);
      check("reset timer_irq", 64'(timer_irq), 64'd0);
      check("bus_stall", 64'(bus_stall), 64'd0);
      rst = 1'b0;

      rd(3'd2, 32'hFFFF_FFFF, "reset mtimecmp_lo");
      rd(3'd3, 32'hFFFF_FFFF, "reset mtimecmp_hi");
      rd(3'd0, 32'd0, "reset mtime_lo");
      rd(3'd1, 32'd0, "reset mtime_hi");
      rd(3'd4, 32'd0, "reset ctrl");
      rd(3'd5, 32'd0, "reset prescale");
      idle();
      check("irq low after reset", 64'(timer_irq), 64'd0);

      // Prescale 3: one tick every 4 cycles; 40 cycles after enabling gives about 10.
      wr(3'd5, 32'd3, 4'hF, "wr prescale 3");
      wr(3'd4, 32'd1, 4'hF, "wr ctrl en");
      repeat (40) idle();
      rd_range_task();

      // Prescale 0, reload mtime: then one tick per cycle.
      wr(3'd5, 32'd0, 4'hF, "wr prescale 0");
      wr(3'd0, 32'd1000, 4'hF, "wr mtime_lo 1000");
      wr(3'd1, 32'd0, 4'hF, "wr mtime_hi 0");
      rd(3'd0, 32'd1000, "mtime step 0");
      rd(3'd0, 32'd1001, "mtime step 1");
      rd(3'd0, 32'd1002, "mtime step 2");

      // Atomic 64-bit read across the low-half wrap.
      wr(3'd0, 32'hFFFF_FFFE, 4'hF, "wr mtime_lo wrap");
      wr(3'd1, 32'd0, 4'hF, "wr mtime_hi wrap");
      rd(3'd0, 32'hFFFF_FFFE, "pre-wrap lo");
      rd(3'd0, 32'hFFFF_FFFF, "wrap-cycle lo");
      rd(3'd1, 32'd0, "wrap-cycle hi shadow");
      rd(3'd0, 32'd1, "post-wrap lo");
      rd(3'd1, 32'd1, "post-wrap hi shadow");

      // Interrupt at mtimecmp = 20 from mtime = 0.
      wr(3'd4, 32'd0, 4'hF, "wr ctrl disable");
      wr(3'd0, 32'd0, 4'hF, "clr mtime_lo");
      wr(3'd1, 32'd0, 4'hF, "clr mtime_hi");
      wr(3'd2, 32'd20, 4'hF, "wr mtimecmp_lo 20");
      wr(3'd3, 32'd0, 4'hF, "wr mtimecmp_hi 0");
      rd(3'd0, 32'd0, "frozen mtime");
      wr(3'd4, 32'd1, 4'hF, "wr ctrl enable");
      e_edge = pos_cnt + 1;
      do idle(); while (!timer_irq && pos_cnt < e_edge + 100);
      check("irq rise latency", 64'(pos_cnt - e_edge), 64'd21);
      check("irq high", 64'(timer_irq), 64'd1);
      rd(3'd4, 32'd3, "ctrl with irq");
      wr(3'd3, 32'd1, 4'hF, "wr mtimecmp_hi 1");
      idle();
      check("irq held one cycle after cmp write", 64'(timer_irq), 64'd1);
      idle();
      check("irq dropped two cycles after cmp write", 64'(timer_irq), 64'd0);

      // Reserved words and a miss.
      access(base_word + 30'd6, 1'b0, 32'd0, 4'd0, K_ERR, 1'b0, 32'd0, 32'd0, "rd 0x18");
      access(base_word + 30'd7, 1'b1, 32'hDEAD_BEEF, 4'hF, K_ERR, 1'b0, 32'd0, 32'd0, "wr 0x1c");
      access(base_word + 30'd8, 1'b0, 32'd0, 4'd0, K_NONE, 1'b0, 32'd0, 32'd0, "rd base+0x20");
      access(base_word + 30'd8, 1'b1, 32'h1, 4'hF, K_NONE, 1'b0, 32'd0, 32'd0, "wr base+0x20");

      // Byte masks and read-only/reserved bits.
      wr(3'd2, 32'hFFFF_FFFF, 4'hF, "wr mtimecmp_lo ones");
      wr(3'd2, 32'h1122_3344, 4'b0101, "wr mtimecmp_lo masked");
      rd(3'd2, 32'hFF22_FF44, "masked mtimecmp_lo");
      wr(3'd5, 32'hABCD_1234, 4'hF, "wr prescale wide");
      rd(3'd5, 32'h0000_1234, "prescale upper zero");
      wr(3'd5, 32'hFFFF_FFFF, 4'h0, "wr prescale mask0");
      rd(3'd5, 32'h0000_1234, "prescale after mask0");
      wr(3'd4, 32'hFFFF_FFFF, 4'hF, "wr ctrl ones");
      rd(3'd4, 32'd1, "ctrl reserved bits");

      // Reset while a read response is on the bus.
      rd(3'd2, 32'hFF22_FF44, "read before reset");
      @(posedge clk);
      #1;
      check("response present before reset", 64'(bus_valid), 64'd1);
      #1;
      rst = 1'b1;
      bus_en = 1'b0;
      sb.delete();
      #1;
      check("valid drops on reset", 64'(bus_valid), 64'd0);
      check("rdata drops on reset", 64'(bus_rdata), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rd(3'd0, 32'd0, "post-reset mtime_lo");
      rd(3'd1, 32'd0, "post-reset mtime_hi");
      rd(3'd2, 32'hFFFF_FFFF, "post-reset mtimecmp_lo");
      rd(3'd3, 32'hFFFF_FFFF, "post-reset mtimecmp_hi");
      rd(3'd4, 32'd0, "post-reset ctrl");
      rd(3'd5, 32'd0, "post-reset prescale");
      repeat (3) idle();
      check("post-reset irq", 64'(timer_irq), 64'd0);
      check("scoreboard drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic rd_range_task();
      access(base_word, 1'b0, 32'd0, 4'd0, K_VALID, 1'b1, 32'd9, 32'd11, "prescaled mtime");
   endtask

endmodule
